// File: rtl/multi_cycle_arithmetic_unit.sv
// multi_cycle_arithmetic_unit: valid/ready integer ALU, single-cycle logic/shift/compare ops plus
// WIDTH-iteration shift-add multiply and restoring divide on operand magnitudes.
module multi_cycle_arithmetic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             divide_by_zero
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_op;
  logic [WIDTH-1:0] r_x, r_hi, r_lo, w_alu, w_ma, w_mb, w_nx_hi, w_nx_lo, w_df;
  logic [SW-1:0] r_cnt, w_sh;
  logic r_neg_lo, r_neg_hi, r_dz;
  logic w_acc, w_mc, w_sgn, w_an, w_bn, w_last, w_ge, w_div;
  logic [WIDTH:0] w_sum, w_rs;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready = reset_n && !flush && (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_acc = in_valid && in_ready;
  assign w_mc = op >= 4'd11 && op <= 4'd14;
  assign w_sgn = op == 4'd11 || op == 4'd13;
  assign w_an = w_sgn && operand1[WIDTH-1];
  assign w_bn = w_sgn && operand2[WIDTH-1];
  assign w_ma = w_an ? -operand1 : operand1;
  assign w_mb = w_bn ? -operand2 : operand2;
  assign w_sh = operand1[SW-1:0];
  assign w_last = r_cnt == SW'(WIDTH - 1);
  assign w_div = r_op == 4'd13 || r_op == 4'd14;
  assign out_valid = r_state == DONE;
  assign divide_by_zero = out_valid && r_dz;
  assign result_lo = r_lo;
  assign result_hi = r_hi;

  always_comb begin
    w_alu = '0;
    case (op)
      4'd0:    w_alu = operand1 + operand2;
      4'd1:    w_alu = operand1 - operand2;
      4'd2:    w_alu = $unsigned($signed(operand2) >>> w_sh);
      4'd3:    w_alu = operand2 >> w_sh;
      4'd4:    w_alu = operand2 << w_sh;
      4'd5:    w_alu = operand1 & operand2;
      4'd6:    w_alu = operand1 | operand2;
      4'd7:    w_alu = operand1 ^ operand2;
      4'd8:    w_alu = ~(operand1 | operand2);
      4'd9:    w_alu = WIDTH'($signed(operand1) < $signed(operand2));
      4'd10:   w_alu = WIDTH'(operand1 < operand2);
      default: w_alu = '0;
    endcase
  end

  // Multiply: {hi,lo} starts as {0, multiplier}; each step adds r_x into hi on lo[0] and shifts right.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_x} : '0);
  assign w_prod = {w_sum, r_lo[WIDTH-1:1]};
  // Divide: lo shifts dividend bits out into the partial remainder in hi and quotient bits in.
  assign w_rs = {r_hi, r_lo[WIDTH-1]};
  assign w_ge = w_rs >= {1'b0, r_x};
  assign w_df = w_rs[WIDTH-1:0] - r_x;

  always_comb begin
    {w_nx_hi, w_nx_lo} = (w_last && r_neg_lo) ? -w_prod : w_prod;
    if (w_div) begin
      w_nx_hi = w_ge ? w_df : w_rs[WIDTH-1:0];
      w_nx_lo = {r_lo[WIDTH-2:0], w_ge};
      if (w_last) begin
        w_nx_hi = r_neg_hi ? -w_nx_hi : w_nx_hi;
        w_nx_lo = r_neg_lo ? -w_nx_lo : w_nx_lo;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    if (!flush)
      w_next = r_state == COMPUTE ? (w_last ? DONE : COMPUTE) :
               w_acc ? (w_mc ? COMPUTE : DONE) :
               (r_state == DONE && !out_ready) ? DONE : IDLE;
  end

  // A zero divisor leaves quotient all ones and the remainder equal to |dividend|, so only
  // the quotient sign fix is suppressed to return the raw dividend in hi.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= '0;
      r_x <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_cnt <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz <= 1'b0;
    end else if (w_acc) begin
      r_op <= op;
      r_x <= w_mb;
      r_hi <= '0;
      r_lo <= w_mc ? w_ma : w_alu;
      r_cnt <= '0;
      r_neg_lo <= (w_an ^ w_bn) && |operand2;
      r_neg_hi <= w_an;
      r_dz <= (op == 4'd13 || op == 4'd14) && ~|operand2;
    end else if (r_state == COMPUTE && !flush) begin
      r_hi <= w_nx_hi;
      r_lo <= w_nx_lo;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_cycle_arithmetic_unit.sv
// tb_multi_cycle_arithmetic_unit: directed requests push expected results into a queue; a
// negedge monitor pops and compares results, latency, handshake, flush and reset behaviour.
module tb_multi_cycle_arithmetic_unit;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  logic clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [3:0] op = '0;
  logic [W-1:0] operand1 = '0, operand2 = '0;
  logic in_ready, out_valid, divide_by_zero;
  logic [W-1:0] result_lo, result_hi;
  exp_t q[$];
  int cyc = 0, n_run = 0, n_fail = 0, timeouts = 0;
  bit done = 0, seen = 0, rs_prev = 0, fl_prev = 0;

  multi_cycle_arithmetic_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand1(operand1), .operand2(operand2), .out_valid(out_valid),
    .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi),
    .divide_by_zero(divide_by_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input logic e_dz,
                      input int lat, input bit keep);
    bit got;
    got = 0;
    op = o;
    operand1 = a;
    operand2 = b;
    in_valid = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = in_ready;
    end
    if (!got) timeouts++;
    else begin
      #1;
      if (keep) q.push_back('{lo: e_lo, hi: e_hi, dz: e_dz, acc: cyc, lat: lat});
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("reset_ctl", {out_valid, in_ready, divide_by_zero}, 64'd0);
        chk("reset_data", {result_hi, result_lo}, 64'd0);
        seen = 0;
      end else begin
        if ((rs_prev || fl_prev) && !flush) chk("resume", {out_valid, in_ready}, 64'd1);
        if (out_valid) begin
          if (q.size() == 0) chk("unexpected_valid", out_valid, 64'd0);
          else begin
            if (!seen) chk("latency", cyc - q[0].acc, q[0].lat);
            seen = 1;
            chk("result", {result_hi, result_lo}, {q[0].hi, q[0].lo});
            chk("div_by_zero", divide_by_zero, q[0].dz);
            chk("in_ready_done", in_ready, out_ready && !flush);
            if (out_ready && !flush) begin
              void'(q.pop_front());
              seen = 0;
            end
          end
        end
      end
      rs_prev = !reset_n;
      fl_prev = flush;
      if (done) begin
        chk("queue_drained", q.size(), 64'd0);
        chk("timeouts", timeouts, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1;
    @(posedge clock);
    #1;
    send(4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 1, 1);
    send(4'd2, 32'd4, 32'h80000000, 32'hF8000000, 32'd0, 0, 1, 1);
    send(4'd3, 32'd4, 32'h80000000, 32'h08000000, 32'd0, 0, 1, 1);
    send(4'd4, 32'd33, 32'd3, 32'd6, 32'd0, 0, 1, 1);
    send(4'd9, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 0, 1, 1);
    send(4'd10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 1, 1);
    send(4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 32'd0, 0, 1, 1);
    send(4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 32'd0, 0, 1, 1);
    send(4'd6, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 32'd0, 0, 1, 1);
    send(4'd7, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 32'd0, 0, 1, 1);
    send(4'd8, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0, 32'd0, 0, 1, 1);
    send(4'd15, 32'd5, 32'd6, 32'd0, 32'd0, 0, 1, 1);
    send(4'd11, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 0, 33, 1);
    send(4'd12, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 33, 1);
    send(4'd11, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 0, 33, 1);
    send(4'd13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33, 1);
    send(4'd14, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1, 33, 1);
    send(4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 33, 1);
    send(4'd13, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 33, 1);
    send(4'd14, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 1);
    in_valid = 0;
    repeat (40) @(posedge clock);
    #1;
    // Result held with out_ready low while the request inputs wander.
    out_ready = 0;
    send(4'd12, 32'd3, 32'd4, 32'd12, 32'd0, 0, 33, 1);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clock);
        got = out_valid;
      end
      if (!got) timeouts++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      op = 4'($urandom);
      operand1 = $urandom;
      operand2 = $urandom;
    end
    out_ready = 1;
    send(4'd0, 32'd2, 32'd3, 32'd5, 32'd0, 0, 1, 1);
    in_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    send(4'd14, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 0);
    in_valid = 0;
    repeat (9) @(posedge clock);
    #1;
    flush = 1;
    @(posedge clock);
    #1;
    flush = 0;
    repeat (40) @(posedge clock);
    #1;
    send(4'd13, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 0, 0, 0);
    in_valid = 0;
    repeat (5) @(posedge clock);
    #2;
    reset_n = 0;
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1;
    @(posedge clock);
    #1;
    send(4'd0, 32'd1, 32'd1, 32'd2, 32'd0, 0, 1, 1);
    in_valid = 0;
    repeat (5) @(posedge clock);
    #1;
    done = 1;
  end
endmodule

// File: doc/multi_cycle_arithmetic_unit.md
MULTI_CYCLE_ARITHMETIC_UNIT -- requirements
Module: multi_cycle_arithmetic_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; power of two, 8..64.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: flush  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port: op  input  4  0 ADD, 1 SUB, 2 SRA, 3 SRL, 4 SLL, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MUL, 12 MULU, 13 DIV, 14 DIVU, 15 reserved.
REQ-008 SHALL have port: operand1  input  WIDTH  first operand; low log2(WIDTH) bits are the shift amount.
REQ-009 SHALL have port: operand2  input  WIDTH  second operand; the shifted value for shifts.
REQ-010 SHALL have port: out_valid  output  1  result present.
REQ-011 SHALL have port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port: result_lo  output  WIDTH  primary result, product low half, or quotient.
REQ-013 SHALL have port: result_hi  output  WIDTH  product high half or remainder; 0 for ops 0-10 and 15.
REQ-014 SHALL have port: divide_by_zero  output  1  set with result of DIV/DIVU when operand2 == 0.

Function
REQ-015 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready == 1, and 0 otherwise; it SHALL be 0 whenever flush == 1.
REQ-017 Operands and op SHALL be registered at acceptance; later input changes SHALL NOT affect the result.
REQ-018 Ops 0-10 and 15 SHALL go to DONE the cycle after acceptance (latency 1); reserved op 15 SHALL give result_lo = 0.
REQ-019 Ops 11-14 SHALL go to COMPUTE and spend exactly WIDTH cycles there, one iteration per cycle, then go to DONE (latency WIDTH+1); the latency SHALL NOT depend on operand values.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; shifts SHALL use operand1[log2(WIDTH)-1:0]; SRA SHALL sign-extend; SLT/SLTU SHALL give 0 or 1 zero-extended.
REQ-021 MUL (signed) and MULU (unsigned) SHALL give the full 2*WIDTH-bit product as {result_hi, result_lo}.
REQ-022 DIV/DIVU SHALL give the quotient in result_lo and the remainder in result_hi; signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-023 Divide by zero SHALL give result_lo = all ones, result_hi = dividend, and divide_by_zero = 1; latency SHALL be unchanged.
REQ-024 Signed DIV of most-negative by -1 SHALL give result_lo = most-negative value, result_hi = 0, divide_by_zero = 0.
REQ-025 In DONE, out_valid SHALL be 1 and all result outputs SHALL hold stable until out_ready == 1.
REQ-026 DONE with out_ready == 1 and in_valid == 0 SHALL go to IDLE.
REQ-027 DONE with out_ready == 1 and in_valid == 1 SHALL accept the new request in the same cycle, with no idle bubble.
REQ-028 When flush == 1, the next state SHALL be IDLE and out_valid SHALL be 0 the following cycle; any in-flight or held result SHALL be discarded; flush SHALL take priority over accept and complete.
REQ-029 out_valid SHALL be 0 in IDLE and COMPUTE; divide_by_zero SHALL be 0 except with a valid DIV/DIVU result.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, out_valid 0, in_ready 0, result_lo 0, result_hi 0, divide_by_zero 0, and clear the iteration counter, regardless of clock.
REQ-031 Reset asserted mid-COMPUTE SHALL abandon the operation; after reset_n rises, in_ready SHALL be 1 on the first clock edge, and no stale out_valid SHALL appear.

Verification (WIDTH=32)
REQ-032 ADD 0xFFFFFFFF + 1, out_ready=1 -> out_valid one cycle after accept, result_lo 0, result_hi 0.
REQ-033 SRA operand1=4, operand2=0x80000000 -> result_lo 0xF8000000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
REQ-034 MUL -3 x 5 -> out_valid exactly 33 cycles after accept, {hi,lo} = 0xFFFFFFFF_FFFFFFF1; MULU 0xFFFFFFFF x 2 -> hi 1, lo 0xFFFFFFFE.
REQ-035 DIV -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 9/0 -> lo 0xFFFFFFFF, hi 9, divide_by_zero 1; DIV 0x80000000/-1 -> lo 0x80000000, hi 0.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while changing inputs -> outputs stable, in_ready 0; then out_ready=1 with in_valid=1 -> next request accepted in the same cycle.
REQ-037 Flush at COMPUTE cycle 10 -> out_valid never asserts for that op, in_ready 1 the next cycle; reset_n pulse mid-DIV -> all outputs 0 asynchronously.
